// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one BRAM port between fetch and data ports
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [31:0] LIMIT = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic        owner_i;       // 1 = fetch port owns the current transaction
    logic        last_i;        // 1 = fetch port was served last
    logic [31:0] cnt;
    logic        grant, grant_i, timeout_hit, done;

    always_comb begin
        state_nx    = state;
        grant       = 1'b0;
        grant_i     = 1'b0;
        timeout_hit = 1'b0;
        done        = 1'b0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        i_rdata     = 32'h0;
        d_rdata     = 32'h0;
        case (state)
            IDLE: begin
                if (i_valid || d_valid) begin
                    grant    = 1'b1;
                    grant_i  = i_valid && (!d_valid || !last_i);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // A real completion beats the timeout when both land together.
                timeout_hit = (TIMEOUT != 0) && (cnt == LIMIT) && !mem_ready;
                done        = mem_ready || timeout_hit;
                if (done) begin
                    state_nx = IDLE;
                    i_ready  = owner_i;
                    d_ready  = !owner_i;
                    if (mem_ready) begin
                        i_rdata = owner_i ? mem_rdata : 32'h0;
                        d_rdata = owner_i ? 32'h0 : mem_rdata;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_i   <= 1'b0;
            last_i    <= 1'b0;
            cnt       <= 32'h0;
            err       <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
        end else if (grant) begin
            owner_i   <= grant_i;
            mem_valid <= 1'b1;
            cnt       <= 32'h0;
            mem_addr  <= grant_i ? i_addr : d_addr;
            mem_wdata <= grant_i ? 32'h0 : d_wdata;
            mem_wstrb <= grant_i ? 4'h0 : d_wstrb;
        end else if (state == BUSY) begin
            if (cnt != 32'hFFFF_FFFF) begin
                cnt <= cnt + 32'h1;
            end
            if (done) begin
                mem_valid <= 1'b0;
                last_i    <= owner_i;
                if (timeout_hit) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a 3-wait BRAM model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0, d_valid = 1'b0;
    logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;

    logic        i_ready, d_ready, mem_valid, mem_ready, err;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        i_ready4, d_ready4, mem_valid4, err4;
    logic [31:0] i_rdata4, d_rdata4, mem_addr4, mem_wdata4;
    logic [3:0]  mem_wstrb4;
    logic        m4_ready = 1'b0;
    logic [31:0] m4_rdata = 32'h0;

    logic        bram_en = 1'b1, man_ready = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        bram_ready;
    logic [31:0] bram_rdata;
    logic [1:0]  wcnt;
    logic [31:0] bram [0:255];

    int checks = 0, failures = 0, n_ready = 0;
    logic sb_on = 1'b1;
    logic [32:0] sb_q[$];
    logic        prev_valid = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always #5 clk = ~clk;

    assign mem_ready = bram_en ? bram_ready : man_ready;
    assign mem_rdata = bram_en ? bram_rdata : man_rdata;

    mem_arbiter #(.TIMEOUT(8)) u_dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .err(err)
    );

    mem_arbiter #(.TIMEOUT(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready4), .i_addr(i_addr), .i_rdata(i_rdata4),
        .d_valid(d_valid), .d_ready(d_ready4), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata4),
        .mem_valid(mem_valid4), .mem_ready(m4_ready), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_wstrb(mem_wstrb4), .mem_rdata(m4_rdata),
        .err(err4)
    );

    // BRAM controller: ready on the 4th cycle of mem_valid; writes return 0.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt       <= 2'd0;
            bram_ready <= 1'b0;
            bram_rdata <= 32'h0;
        end else begin
            bram_ready <= 1'b0;
            if (bram_en && mem_valid && !bram_ready) begin
                if (wcnt == 2'd2) begin
                    wcnt       <= 2'd0;
                    bram_ready <= 1'b1;
                    bram_rdata <= (mem_wstrb == 4'h0) ? bram[mem_addr[9:2]] : 32'h0;
                    if (mem_wstrb == 4'hF) bram[mem_addr[9:2]] <= mem_wdata;
                end else begin
                    wcnt <= wcnt + 2'd1;
                end
            end else begin
                wcnt <= 2'd0;
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] exp, got;
        if (sb_on && !reset) begin
            if (mem_valid && prev_valid) begin
                checks++;
                if (mem_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL mem_addr_stable: got %h, required %h", mem_addr, prev_addr);
                end
            end
            if (i_ready || d_ready) begin
                n_ready++;
                checks++;
                got = i_ready ? {1'b1, i_rdata} : {1'b0, d_rdata};
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_ready: got port/data %h, required no ready", got);
                end else begin
                    exp = sb_q.pop_front();
                    if ((i_ready && d_ready) || got !== exp) begin
                        failures++;
                        $display("FAIL sb_response: got i=%b d=%b port/data %h, required %h",
                                 i_ready, d_ready, got, exp);
                    end
                end
            end
        end
        prev_valid = mem_valid && !reset;
        prev_addr  = mem_addr;
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (i_ready || d_ready) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_valid = 1'b1; d_valid = 1'b1; i_addr = 32'h10; d_addr = 32'h80;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_valid, i_ready, d_ready, err, mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b ir=%b dr=%b err=%b addr=%h, required all zero",
                     mem_valid, i_ready, d_ready, err, mem_addr);
        end
        i_valid = 1'b0; d_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_single_fetch();
        int cyc;
        @(posedge clk);
        #1 i_valid = 1'b1; i_addr = 32'h10;
        sb_q.push_back({1'b1, 32'h0000_006F});
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
            failures++; $display("FAIL fetch_no_early_valid: got %b, required 0", mem_valid);
        end
        @(negedge clk);
        checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h10, 4'h0, 32'h0}) begin
            failures++;
            $display("FAIL fetch_request: got v=%b a=%h s=%h, required v=1 a=10 s=0", mem_valid, mem_addr, mem_wstrb);
        end
        wait_ready(cyc);
        checks++;
        if (cyc != 3 || i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== 32'h6F) begin
            failures++;
            $display("FAIL fetch_latency: got cyc=%0d ir=%b dr=%b rd=%h, required 3 1 0 6f", cyc, i_ready, d_ready, i_rdata);
        end
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic test_data_write_read();
        int cyc;
        @(posedge clk);
        #1 d_valid = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFE_BABE; d_wstrb = 4'hF;
        sb_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h80, 32'hCAFE_BABE, 4'hF}) begin
            failures++;
            $display("FAIL write_request: got a=%h w=%h s=%h, required 80 cafebabe f", mem_addr, mem_wdata, mem_wstrb);
        end
        wait_ready(cyc);
        checks++;
        if (cyc != 3 || d_ready !== 1'b1 || i_ready !== 1'b0) begin
            failures++; $display("FAIL write_ready: got cyc=%0d dr=%b ir=%b, required 3 1 0", cyc, d_ready, i_ready);
        end
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(posedge clk);
        #1 d_valid = 1'b1; d_wdata = 32'h0; d_wstrb = 4'h0;
        sb_q.push_back({1'b0, 32'hCAFE_BABE});
        wait_ready(cyc);
        checks++;
        if (d_rdata !== 32'hCAFE_BABE) begin
            failures++; $display("FAIL read_back: got %h, required cafebabe", d_rdata);
        end
        @(posedge clk);
        #1 d_valid = 1'b1; d_addr = 32'h84; d_wdata = 32'h55; d_wstrb = 4'b0101;
        sb_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_wstrb !== 4'b0101) begin
            failures++; $display("FAIL wstrb_passthrough: got %b, required 0101", mem_wstrb);
        end
        wait_ready(cyc);
        @(posedge clk);
        #1 d_valid = 1'b0;
    endtask

    task automatic test_contention();
        int cyc;
        logic exp_i;
        i_valid = 1'b1; i_addr = 32'h10; d_valid = 1'b1; d_addr = 32'h80; d_wstrb = 4'h0;
        n_ready = 0;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb_q.push_back({1'b1, 32'h6F});
            else            sb_q.push_back({1'b0, 32'hCAFE_BABE});
        end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_i = (k % 2 == 0);
            wait_ready(cyc);
            checks++;
            if (cyc != 5 || i_ready !== exp_i || d_ready !== !exp_i) begin
                failures++;
                $display("FAIL contention_%0d: got cyc=%0d ir=%b dr=%b, required 5 %b %b", k, cyc, i_ready, d_ready, exp_i, !exp_i);
            end
        end
        @(posedge clk);
        #1 i_valid = 1'b0; d_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (n_ready != 4 || sb_q.size() != 0) begin
            failures++; $display("FAIL contention_count: got readies=%0d left=%0d, required 4 0", n_ready, sb_q.size());
        end
    endtask

    task automatic test_collision();
        sb_on = 1'b0;
        bram_en = 1'b0;
        do_reset();
        @(posedge clk);
        #1 d_valid = 1'b1; d_addr = 32'h44; d_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (d_ready4 !== 1'b0 || mem_valid4 !== 1'b1) begin
            failures++; $display("FAIL collision_pre: got dr=%b v=%b, required 0 1", d_ready4, mem_valid4);
        end
        @(posedge clk);
        #1 m4_ready = 1'b1; m4_rdata = 32'h1234;
        @(negedge clk);
        checks++;
        if (d_ready4 !== 1'b1 || d_rdata4 !== 32'h1234 || i_ready4 !== 1'b0) begin
            failures++; $display("FAIL collision_data: got dr=%b rd=%h, required 1 1234", d_ready4, d_rdata4);
        end
        @(posedge clk);
        #1 m4_ready = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err4 !== 1'b0 || mem_valid4 !== 1'b0) begin
            failures++; $display("FAIL collision_err: got err=%b v=%b, required 0 0", err4, mem_valid4);
        end
        do_reset();
        sb_on = 1'b1;
    endtask

    task automatic test_timeout();
        int cyc;
        bram_en = 1'b0; man_ready = 1'b0;
        @(posedge clk);
        #1 d_valid = 1'b1; d_addr = 32'h40; d_wstrb = 4'h0;
        sb_q.push_back({1'b0, 32'h0});
        wait_ready(cyc);
        checks++;
        if (cyc != 9 || d_ready !== 1'b1 || d_rdata !== 32'h0 || err !== 1'b0) begin
            failures++; $display("FAIL timeout_pulse: got cyc=%0d dr=%b rd=%h err=%b, required 9 1 0 0", cyc, d_ready, d_rdata, err);
        end
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || mem_valid !== 1'b0) begin
            failures++; $display("FAIL timeout_err: got err=%b v=%b, required 1 0", err, mem_valid);
        end
        @(posedge clk);
        #1 man_ready = 1'b1; man_rdata = 32'hDEAD;
        @(negedge clk);
        checks++;
        if (i_ready !== 1'b0 || d_ready !== 1'b0 || err !== 1'b1) begin
            failures++; $display("FAIL late_ready: got ir=%b dr=%b err=%b, required 0 0 1", i_ready, d_ready, err);
        end
        @(posedge clk);
        #1 man_ready = 1'b0; bram_en = 1'b1;
    endtask

    task automatic test_async_reset();
        int cyc;
        @(posedge clk);
        #1 i_valid = 1'b1; i_addr = 32'h10;
        sb_q.push_back({1'b1, 32'h6F});
        wait_ready(cyc);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mem_valid, i_ready, d_ready, err, i_rdata} !== '0) begin
            failures++; $display("FAIL async_reset: got v=%b ir=%b dr=%b err=%b, required all 0", mem_valid, i_ready, d_ready, err);
        end
        i_valid = 1'b1; d_valid = 1'b1; i_addr = 32'h10; d_addr = 32'h80; d_wstrb = 4'h0;
        sb_q.push_back({1'b1, 32'h6F});
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h10) begin
            failures++; $display("FAIL post_reset_tie: got v=%b a=%h, required 1 10", mem_valid, mem_addr);
        end
        wait_ready(cyc);
        @(posedge clk);
        #1 i_valid = 1'b0; d_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size());
        end
    endtask

    initial begin
        bram[8'h04] = 32'h0000_006F;
        test_reset();
        test_single_fetch();
        test_data_write_read();
        test_contention();
        test_collision();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares one BRAM controller memory port (valid/ready/addr/wdata/wstrb/rdata) between the CPU instruction-fetch port (i_*) and data port (d_*).
- Sits between the core and the BRAM controller.
- Registers and holds the winning request on the downstream port for the whole transaction.
- Alternates grants round-robin when both ports request.
- Aborts a transaction that exceeds a cycle budget and flags the error.

Parameters:
TIMEOUT, 255, max cycles in BUSY before abort; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
i_valid  input  1  fetch request; held with i_addr stable until i_ready
i_ready  output  1  one-cycle completion pulse to the fetch port
i_addr  input  32  fetch byte address
i_rdata  output  32  fetch read data, valid while i_ready=1
d_valid  input  1  data request; held with d_addr/d_wdata/d_wstrb stable until d_ready
d_ready  output  1  one-cycle completion pulse to the data port
d_addr  input  32  data byte address
d_wdata  input  32  write data
d_wstrb  input  4  4'b0000 = read, 4'b1111 = word write
d_rdata  output  32  data read data, valid while d_ready=1
mem_valid  output  1  downstream request (registered)
mem_ready  input  1  downstream completion pulse
mem_addr  output  32  downstream address (registered)
mem_wdata  output  32  downstream write data (registered)
mem_wstrb  output  4  downstream strobe (registered)
mem_rdata  input  32  downstream read data
err  output  1  sticky timeout flag

Behaviour:
- Reset (async, asserted): state=IDLE, owner=D, last=D, timeout counter=0, err=0, mem_valid=0, mem_addr/mem_wdata/mem_wstrb=0. i_ready=d_ready=0, i_rdata=d_rdata=0.
- States: IDLE, BUSY.
- IDLE, no request: remain in IDLE, mem_valid=0.
- IDLE, only i_valid: set owner=I.
- IDLE, only d_valid: set owner=D.
- IDLE, both valid: owner = the port that is not last. Because last resets to D, the fetch port wins the first tie.
- IDLE, on grant (same clock edge):
  - Load mem_addr from the owner. For I: mem_wdata=0, mem_wstrb=4'b0000. For D: mem_wdata=d_wdata, mem_wstrb=d_wstrb.
  - Set mem_valid=1, counter=0, go to BUSY.
- BUSY, general: mem_* outputs stay constant. Counter increments each cycle, saturating.
- BUSY, mem_ready=1:
  - Owner's ready = 1 combinationally in the same cycle; owner's rdata = mem_rdata combinationally.
  - The non-owner's ready stays 0 and its rdata reads 0.
  - At the clock edge: mem_valid=0, last=owner, state=IDLE.
- BUSY, TIMEOUT!=0, counter==TIMEOUT-1, mem_ready=0:
  - Owner's ready = 1 with rdata=32'h0000_0000.
  - At the clock edge: err=1 (sticky until reset), mem_valid=0, last=owner, state=IDLE.
  - A late mem_ready arriving in IDLE is ignored and is not forwarded.
- mem_ready and the timeout in the same cycle: mem_ready wins (real data returned, err unchanged).
- No grant is made in the cycle a transaction completes; the next arbitration is evaluated in IDLE on the following cycle.
- Latency: request first seen in IDLE at cycle N -> mem_valid=1 from cycle N+1. With the 3-wait BRAM controller, ready at N+4. Back-to-back issue rate: one transaction per 5 cycles.
- Requester drops valid mid-transaction (protocol violation): the downstream transaction still completes and the ready pulse is still produced.
- Reset asserted mid-BUSY: all outputs clear immediately; the pending transaction is abandoned.
- mem_wstrb values other than 0000/1111 are passed through unmodified; the arbiter does not check them.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x10 -> mem_valid rises 1 cycle later with mem_addr=0x10, mem_wstrb=0000. When mem_ready pulses with mem_rdata=0x0000006F, i_ready=1 and i_rdata=0x0000006F in that cycle; d_ready stays 0.
- Data write then read: d_addr=0x80, d_wdata=0xCAFEBABE, d_wstrb=1111 -> mem_* carry those values, d_ready pulses once. A following read of 0x80 returns d_rdata=0xCAFEBABE (BRAM model attached).
- Contention: i_valid and d_valid both held high continuously from reset release -> grant order I, D, I, D. Each port receives exactly one ready per transaction; mem_addr never changes while mem_valid=1.
- Timeout: TIMEOUT=8, downstream never asserts ready -> owner ready pulses on the 8th BUSY cycle with rdata=0, err=1 and stays 1. A mem_ready pulsed 2 cycles later produces no upstream ready.
- Ready/timeout collision: TIMEOUT=4, mem_ready on the 4th BUSY cycle with mem_rdata=0x1234 -> rdata=0x1234, err stays 0.
- Async reset mid-BUSY: assert reset between clock edges -> mem_valid, i_ready, d_ready, err go 0 without waiting for a clock. After release, the first tie is granted to I.
